// File: rtl/kbest_path_elect.sv
// K-best survivor election: merges K ascending groups of 4 child paths and emits the K
// smallest-PED paths in order. Optional KBEST_PED_NORM_EN reports PEDs relative to the frame minimum.
`ifndef ERR_WL
`define ERR_WL 16
`endif

module kbest_path_elect #(
  parameter int N = 2,
  parameter int K = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [K*4*N*2-1:0]     PATH_in,
  input  logic [K*4*`ERR_WL-1:0] PED_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*2-1:0]         out_path,
  output logic [`ERR_WL-1:0]     out_ped,
  output logic [2:0]             out_grp,
  output logic                   out_last
);

  localparam int PW = N * 2;
  localparam int EW = `ERR_WL;
  localparam logic [2:0] LastCount = 3'(K - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] EMIT   = 2'd2;

  logic [1:0]    state_q;
  logic [2:0]    count_q;
  logic [EW-1:0] ped_q  [K][4];
  logic [PW-1:0] path_q [K][4];

  logic [2:0]    win_grp;
  logic [EW-1:0] win_ped;
  logic [PW-1:0] win_path;
  logic [EW-1:0] win_ped_rep;

  // Scan heads in ascending group order; strict < keeps the lowest group on a tie.
  always_comb begin
    win_grp  = '0;
    win_ped  = ped_q[0][0];
    win_path = path_q[0][0];
    for (int g = 1; g < K; g++) begin
      if (ped_q[g][0] < win_ped) begin
        win_grp  = 3'(g);
        win_ped  = ped_q[g][0];
        win_path = path_q[g][0];
      end
    end
  end

`ifdef KBEST_PED_NORM_EN
  logic [EW-1:0] base_q;
  logic [EW-1:0] base_d;

  always_comb begin
    base_d = PED_in[0 +: EW];
    for (int g = 1; g < K; g++) begin
      if (PED_in[(g*4)*EW +: EW] < base_d) base_d = PED_in[(g*4)*EW +: EW];
    end
  end

  // base is the smallest head, so every winner is >= base.
  assign win_ped_rep = win_ped - base_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      base_q <= base_d;
    end
  end
`else
  assign win_ped_rep = win_ped;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) && (count_q == LastCount);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      out_path <= '0;
      out_ped  <= '0;
      out_grp  <= '0;
      for (int g = 0; g < K; g++) begin
        for (int s = 0; s < 4; s++) begin
          ped_q[g][s]  <= '1;
          path_q[g][s] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int g = 0; g < K; g++) begin
              for (int s = 0; s < 4; s++) begin
                ped_q[g][s]  <= PED_in[(g*4+s)*EW +: EW];
                path_q[g][s] <= PATH_in[(g*4+s)*PW +: PW];
              end
            end
            count_q <= '0;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          out_path <= win_path;
          out_ped  <= win_ped_rep;
          out_grp  <= win_grp;
          state_q  <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            // Pop the emitted head; the refill value can never win within a frame.
            for (int g = 0; g < K; g++) begin
              if (out_grp == 3'(g)) begin
                for (int s = 0; s < 3; s++) begin
                  ped_q[g][s]  <= ped_q[g][s+1];
                  path_q[g][s] <= path_q[g][s+1];
                end
                ped_q[g][3]  <= '1;
                path_q[g][3] <= '0;
              end
            end
            count_q <= count_q + 3'd1;
            state_q <= (count_q == LastCount) ? IDLE : SELECT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbest_path_elect.sv
// Randomized self-checking bench for kbest_path_elect; the reference picks the K smallest
// candidates by (PED, group, slot) over the whole frame. Honours KBEST_PED_NORM_EN if defined.
`ifndef ERR_WL
`define ERR_WL 16
`endif

module tb_kbest_path_elect;

  localparam int N  = 2;
  localparam int K  = 4;
  localparam int PW = N * 2;
  localparam int EW = `ERR_WL;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [K*4*PW-1:0]    PATH_in = '0;
  logic [K*4*EW-1:0]    PED_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [PW-1:0]        out_path;
  logic [EW-1:0]        out_ped;
  logic [2:0]           out_grp;
  logic                 out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] f_ped  [K][4];
  logic [PW-1:0] f_path [K][4];
  logic [EW-1:0] e_ped  [K];
  logic [PW-1:0] e_path [K];
  int            e_grp  [K];

  kbest_path_elect #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .PATH_in   (PATH_in),
    .PED_in    (PED_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_path  (out_path),
    .out_ped   (out_ped),
    .out_grp   (out_grp),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int g = 0; g < K; g++) begin
      for (int s = 0; s < 4; s++) begin
        PED_in[(g*4+s)*EW +: EW]  = f_ped[g][s];
        PATH_in[(g*4+s)*PW +: PW] = f_path[g][s];
      end
    end
  endtask

  // Reference: K rounds of picking the smallest unused candidate, ordered by (PED, group, slot).
  task automatic build_expect();
    bit            used [K][4];
    logic [EW-1:0] base;
    int            bg;
    int            bs;
    base = f_ped[0][0];
    for (int g = 0; g < K; g++) begin
      for (int s = 0; s < 4; s++) used[g][s] = 1'b0;
      if (f_ped[g][0] < base) base = f_ped[g][0];
    end
    for (int i = 0; i < K; i++) begin
      bg = -1;
      bs = 0;
      for (int g = 0; g < K; g++) begin
        for (int s = 0; s < 4; s++) begin
          if (!used[g][s] && (bg < 0 || f_ped[g][s] < f_ped[bg][bs])) begin
            bg = g;
            bs = s;
          end
        end
      end
      used[bg][bs] = 1'b1;
      e_grp[i]  = bg;
      e_path[i] = f_path[bg][bs];
`ifdef KBEST_PED_NORM_EN
      e_ped[i]  = f_ped[bg][bs] - base;
`else
      e_ped[i]  = f_ped[bg][bs];
`endif
    end
  endtask

  task automatic rand_frame();
    logic [EW-1:0] v [4];
    logic [EW-1:0] t;
    for (int g = 0; g < K; g++) begin
      for (int s = 0; s < 4; s++) begin
        v[s] = EW'($urandom_range(0, 40));
        f_path[g][s] = PW'($urandom);
      end
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 3 - a; b++) begin
          if (v[b] > v[b+1]) begin
            t = v[b]; v[b] = v[b+1]; v[b+1] = t;
          end
        end
      end
      for (int s = 0; s < 4; s++) f_ped[g][s] = v[s];
    end
  endtask

  task automatic set_frame(input int h0, input int h1, input int h2, input int h3,
                           input int n0, input int n1, input int n2, input int n3);
    int a0 [K];
    int a1 [K];
    a0[0] = h0; a0[1] = h1; a0[2] = h2; a0[3] = h3;
    a1[0] = n0; a1[1] = n1; a1[2] = n2; a1[3] = n3;
    for (int g = 0; g < K; g++) begin
      f_ped[g][0] = EW'(a0[g]);
      f_ped[g][1] = EW'(a1[g]);
      f_ped[g][2] = EW'(50 + g);
      f_ped[g][3] = EW'(60 + g);
      for (int s = 0; s < 4; s++) f_path[g][s] = PW'(g * 4 + s);
    end
  endtask

  task automatic send_frame();
    int n;
    pack();
    build_expect();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    tick();
    // Garbage offered while busy must be ignored.
    PED_in  = ~PED_in;
    PATH_in = ~PATH_in;
  endtask

  task automatic collect(input int stall_idx, input int abort_idx);
    int n;
    int st;
    for (int i = 0; i < K; i++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check("latency", n, 1);
      check("out_ped", out_ped, e_ped[i]);
      check("out_grp", out_grp, e_grp[i]);
      check("out_path", out_path, e_path[i]);
      check("out_last", out_last, (i == K - 1));
      check("busy_in_ready", in_ready, 0);
      if (i == abort_idx) begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_last", out_last, 0);
        rst_n = 1'b1;
        return;
      end
      st = (i == stall_idx) ? 5 : $urandom_range(0, 2);
      for (int c = 0; c < st; c++) begin
        out_ready = 1'b0;
        tick();
        check("stall_valid", out_valid, 1);
        check("stall_ped", out_ped, e_ped[i]);
        check("stall_grp", out_grp, e_grp[i]);
        check("stall_path", out_path, e_path[i]);
        check("stall_in_ready", in_ready, 0);
      end
      in_valid  = (i != K - 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    check("done_in_ready", in_ready, 1);
    check("done_out_valid", out_valid, 0);
  endtask

  initial begin
    // Reset held with a frame offered: nothing may be captured.
    set_frame(5, 3, 9, 7, 6, 4, 10, 8);
    pack();
    in_valid = 1'b1;
    rst_n    = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_last", out_last, 0);
    check("rst_out_ped", out_ped, 0);
    check("rst_out_grp", out_grp, 0);
    check("rst_out_path", out_path, 0);
    rst_n = 1'b1;
    send_frame();
    collect(-1, -1);

    // Same frame with a 5-cycle stall on the second survivor.
    set_frame(5, 3, 9, 7, 6, 4, 10, 8);
    send_frame();
    collect(1, -1);

    // All heads tie.
    set_frame(4, 4, 4, 4, 9, 9, 9, 9);
    send_frame();
    collect(-1, -1);

    // Reset during the second survivor, then a fresh frame.
    set_frame(5, 3, 9, 7, 6, 4, 10, 8);
    send_frame();
    collect(-1, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_abort_quiet", out_valid, 0);
    end
    set_frame(12, 2, 2, 30, 13, 3, 20, 31);
    send_frame();
    collect(-1, -1);

    for (int f = 0; f < 40; f++) begin
      rand_frame();
      send_frame();
      collect(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, K - 1)) : -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
